misr_bist_compactor: RTL and testbench

- Parametrised multiple-input signature register (MISR) for BIST response compaction. It generalises the fixed-polynomial, ungated MISR to a configurable width, a polynomial mask and a pattern-count window.
- Adds a run/done state machine, per-cycle input qualification, golden-signature compare and serial signature unload.
- Sits between the circuit-under-test outputs and the BIST controller/tester.

---
 rtl/misr_bist_compactor.sv | 107 ++++++++++
 tb/tb_misr_bist_compactor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/misr_bist_compactor.sv
// Galois-form multiple-input signature register for BIST response compaction,
// with a run/done/unload state machine, golden compare and serial unload.
module misr_bist_compactor #(
  parameter int unsigned W        = 16,
  parameter logic [W-1:0] POLY    = W'(16'h002D),
  parameter logic [W-1:0] SEED    = W'(1),
  parameter int unsigned PATTERNS = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic [W-1:0] golden,
  input  logic         unload,
  output logic [W-1:0] sig_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         so,
  output logic         so_valid
);

  localparam int unsigned CntW = $clog2(PATTERNS + 1);
  localparam int unsigned BitW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(PATTERNS - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(W - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StUnload} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    sig_q, sig_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [W-1:0]    misr_next;

  assign misr_next = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ in_data;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          sig_d   = SEED;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (in_valid) begin
          sig_d = misr_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) state_d = StDone;
        end
      end
      StDone: begin
        // start takes priority over unload
        if (start) begin
          state_d = StRun;
          sig_d   = SEED;
          cnt_d   = '0;
        end else if (unload) begin
          state_d = StUnload;
          bit_d   = '0;
        end
      end
      StUnload: begin
        // Rotate right so the signature is intact after W shifts
        sig_d = {sig_q[0], sig_q[W-1:1]};
        if (bit_q == LastBit) begin
          state_d = StDone;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sig_q   <= SEED;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    sig_out  = sig_q;
    busy     = (state_q == StRun) || (state_q == StUnload);
    done     = (state_q == StDone);
    pass     = done && (sig_q == golden);
    so_valid = (state_q == StUnload);
    so       = so_valid & sig_q[0];
  end

endmodule

// File: tb/tb_misr_bist_compactor.sv
// Scoreboard bench: three MISR instances (PATTERNS 16, 1, 4); done rises and
// serial unload bits are checked against queued expectations by a monitor.
module tb_misr_bist_compactor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, unload;
  logic [2:0]  start;
  logic [15:0] in_data, golden;

  logic [15:0] sig_out [3];
  logic        busy [3], done [3], pass [3], so [3], so_valid [3];

  typedef struct packed {
    logic [15:0] sig;
    logic        pass;
  } done_exp_t;

  done_exp_t dq0[$], dq1[$], dq2[$];
  bit        sq[$];
  int        checks = 0;
  int        errors = 0;
  logic      done_d [3];

  misr_bist_compactor #(.PATTERNS(16)) u_p16 (
    .clk(clk), .reset(reset), .start(start[0]), .in_valid(in_valid), .in_data(in_data),
    .golden(golden), .unload(unload), .sig_out(sig_out[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .so(so[0]), .so_valid(so_valid[0])
  );

  misr_bist_compactor #(.PATTERNS(1)) u_p1 (
    .clk(clk), .reset(reset), .start(start[1]), .in_valid(in_valid), .in_data(in_data),
    .golden(golden), .unload(unload), .sig_out(sig_out[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .so(so[1]), .so_valid(so_valid[1])
  );

  misr_bist_compactor #(.PATTERNS(4)) u_p4 (
    .clk(clk), .reset(reset), .start(start[2]), .in_valid(in_valid), .in_data(in_data),
    .golden(golden), .unload(unload), .sig_out(sig_out[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .so(so[2]), .so_valid(so_valid[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_done(input int i);
    done_exp_t e;
    int        n;
    n = (i == 0) ? dq0.size() : (i == 1) ? dq1.size() : dq2.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done[%0d]: got done rise expected none", i);
    end else begin
      if (i == 0) e = dq0.pop_front();
      else if (i == 1) e = dq1.pop_front();
      else e = dq2.pop_front();
      check($sformatf("done_sig[%0d]", i), 32'(sig_out[i]), 32'(e.sig));
      check($sformatf("done_pass[%0d]", i), 32'(pass[i]), 32'(e.pass));
    end
  endtask

  // Monitor: consumes expectations whenever a DUT presents done or a serial bit
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset && done[i] && !done_d[i]) pop_done(i);
      done_d[i] <= done[i];
    end
    if (so_valid[0]) begin
      if (sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_so_valid: got so_valid=1 expected 0");
      end else begin
        check("so_bit", 32'(so[0]), 32'(sq.pop_front()));
      end
    end else begin
      check("so_idle_zero", 32'(so[0]), 32'(0));
    end
    if (so_valid[1] || so_valid[2]) begin
      checks++;
      errors++;
      $display("FAIL stray_so_valid: got 1 expected 0");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [15:0] gated_exp [7];

  initial begin
    reset = 1'b1; start = '0; in_valid = 1'b0; unload = 1'b0;
    in_data = '0; golden = 16'h0001;
    for (int i = 0; i < 3; i++) done_d[i] = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_sig[%0d]", i), 32'(sig_out[i]), 32'h0001);
      check($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'(0));
      check($sformatf("rst_done[%0d]", i), 32'(done[i]), 32'(0));
      check($sformatf("rst_pass[%0d]", i), 32'(pass[i]), 32'(0));
    end

    // PATTERNS=16, zero data, with an ignored start pulse mid-run
    golden = 16'h002D;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    @(negedge clk);
    check("run_busy", 32'(busy[0]), 32'(1));
    check("run_seed", 32'(sig_out[0]), 32'h0001);
    dq0.push_back('{sig: 16'h002D, pass: 1'b1});
    #1;
    in_valid = 1'b1;
    in_data  = 16'h0000;
    for (int i = 0; i < 15; i++) begin
      start[0] = (i == 5);
      tick();
    end
    start[0] = 1'b0;
    @(negedge clk);
    check("not_done_early", 32'(done[0]), 32'(0));
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("done_latency", 32'(done[0]), 32'(1));
    check("done_busy", 32'(busy[0]), 32'(0));
    #1;
    golden = 16'h002C;
    @(negedge clk);
    check("pass_bad_golden", 32'(pass[0]), 32'(0));
    #1;
    golden = 16'h002D;

    // Serial unload of 0x002D, LSB first
    for (int b = 0; b < 16; b++) sq.push_back(bit'((16'h002D >> b) & 16'h1));
    dq0.push_back('{sig: 16'h002D, pass: 1'b1});
    unload = 1'b1;
    tick();
    unload = 1'b0;
    @(negedge clk);
    check("unload_busy", 32'(busy[0]), 32'(1));
    check("unload_done", 32'(done[0]), 32'(0));
    check("unload_pass", 32'(pass[0]), 32'(0));
    #1;
    start[0] = 1'b1;
    unload   = 1'b1;
    tick();
    start[0] = 1'b0;
    unload   = 1'b0;
    repeat (14) tick();
    @(negedge clk);
    check("unload_last_valid", 32'(so_valid[0]), 32'(1));
    tick();
    @(negedge clk);
    check("after_unload_done", 32'(done[0]), 32'(1));
    check("after_unload_sig", 32'(sig_out[0]), 32'h002D);
    check("after_unload_pass", 32'(pass[0]), 32'(1));
    check("unload_bits_left", 32'(sq.size()), 32'(0));

    // Restart from DONE with concurrent unload: start wins
    #1;
    start[0] = 1'b1;
    unload   = 1'b1;
    tick();
    start[0] = 1'b0;
    unload   = 1'b0;
    @(negedge clk);
    check("restart_busy", 32'(busy[0]), 32'(1));
    check("restart_done", 32'(done[0]), 32'(0));
    check("restart_sig", 32'(sig_out[0]), 32'h0001);
    #1;
    do_reset();

    // PATTERNS=1, single word 0xFFFF
    golden = 16'hFFFD;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    dq1.push_back('{sig: 16'hFFFD, pass: 1'b1});
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    tick();
    @(negedge clk);
    check("p1_done", 32'(done[1]), 32'(1));
    check("p1_idle_ignores_valid", 32'(sig_out[0]), 32'h0001);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("p1_done_frozen", 32'(sig_out[1]), 32'hFFFD);
    #1;
    do_reset();

    // PATTERNS=4, gated input
    gated_exp = '{16'h0002, 16'h0002, 16'h0004, 16'h0004, 16'h0008, 16'h0008, 16'h0010};
    golden = 16'h0010;
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    dq2.push_back('{sig: 16'h0010, pass: 1'b1});
    in_data = 16'h0000;
    for (int i = 0; i < 7; i++) begin
      in_valid = ((i % 2) == 0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("gated_sig[%0d]", i), 32'(sig_out[2]), 32'(gated_exp[i]));
      check($sformatf("gated_done[%0d]", i), 32'(done[2]), 32'(i == 6));
      #1;
    end
    do_reset();

    // Reset mid-run after 5 of 16 words
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_data = 16'hFFFF;
    @(negedge clk);
    check("midrst_sig", 32'(sig_out[0]), 32'h0001);
    check("midrst_busy", 32'(busy[0]), 32'(0));
    check("midrst_done", 32'(done[0]), 32'(0));
    repeat (3) tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_hold_sig", 32'(sig_out[0]), 32'h0001);
    check("idle_hold_busy", 32'(busy[0]), 32'(0));
    tick();
    tick();
    check("queues_drained", 32'(dq0.size() + dq1.size() + dq2.size() + sq.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
